monitor_multi: RTL
==================

// Module: monitor_multi
// PURPOSE
//  Multi-channel successor to the single-channel temperature monitor. Classifies N independent BCD
//  temperature channels into NORMAL/BORDERLINE/ATTENTION/EMERGENCY with programmable thresholds.
//  Escalation takes effect on the next clock. De-escalation uses hysteresis plus a persistence count.
//  Delta, sign-change and bad-BCD faults are latched until acknowledged.
//  Sits between the per-channel BCD converters and the display/alarm logic.
// PARAMETERS
//  NUM_CH     4        number of channels
//  DIGITS     3        BCD digits per value; W = 4*DIGITS
//  T_BORDER   12'h400  BORDERLINE lower bound (BCD 40.0)
//  T_ATTN     12'h470  ATTENTION lower bound (BCD 47.0)
//  T_EMERG    12'h500  EMERGENCY lower bound (BCD 50.0)
//  DELTA_MAX  12'h050  max allowed |delta|; strictly greater is a fault
//  HYST       12'h010  hysteresis subtracted from a level's lower bound for de-escalation
//  PERSIST    3        consecutive qualifying samples required to de-escalate (>=1)
// PORTS
//  clk          in   1           system clock
//  rst_n        in   1           synchronous, active-low reset
//  en           in   1           global enable; when low, samples are ignored
//  smp_valid    in   NUM_CH      per-channel sample strobe, one cycle per sample
//  value_bcd    in   NUM_CH*W    packed temperature magnitudes; ch i = [i*W +: W]
//  value_sign   in   NUM_CH      per-channel mode/sign bit
//  delta_bcd    in   NUM_CH*W    packed |new - previous| magnitudes
//  fault_ack    in   NUM_CH      per-channel clear of latched fault
//  state        out  2*NUM_CH    per-channel state, `STATE_* encoding
//  worst_state  out  2           max over the state output
//  fault        out  NUM_CH      per-channel latched fault
//  fault_cause  out  3*NUM_CH    per channel {bad_bcd, sign_chg, delta}, sticky
//  alarm        out  1           OR of fault, or worst_state == EMERGENCY
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): every channel goes to state=NORMAL, counters 0, fault=0, cause=0,
//   first_run=1, worst_state=NORMAL, alarm=0. Reset overrides every other input.
//  A sample is accepted when en && smp_valid[i]. Channels are fully independent; simultaneous
//   strobes on all channels are all processed in the same cycle.
//  BCD compare: packed BCD is compared as unsigned binary. This is valid only when every nibble
//   is <= 9. Any nibble > 9 in value or delta sets bad_bcd.
//  Raw level L from the value: <T_BORDER NORMAL; <T_ATTN BORDERLINE; <T_EMERG ATTENTION;
//   otherwise EMERGENCY.
//  Escalation: if L > state, state<=L on the cycle after acceptance (latency 1). The persist count is cleared.
//  De-escalation: a sample qualifies if value < (lower bound of current state) - HYST. Use BCD
//   subtract, or precompute thresholds as parameters. Qualifying increments persist_cnt; a
//   non-qualifying sample clears it. When the count reaches PERSIST, state<=L and the count is
//   cleared. So with PERSIST=3, the drop is visible 1 cycle after the 3rd qualifying sample.
//  Faults are evaluated only when first_run==0. delta: delta_bcd > DELTA_MAX.
//   sign_chg: value_sign != sign_prev. bad_bcd is evaluated on every sample, including the first.
//   Any fault sets fault[i]=1, ORs the corresponding cause bit, and forces state=EMERGENCY.
//  While fault[i]=1, state stays EMERGENCY and ignores de-escalation. Samples are still accepted,
//   and sign_prev is still updated.
//  fault_ack[i]: clears fault and cause and resets persist_cnt. The state stays EMERGENCY and can
//   then de-escalate via hysteresis. If a fault event and ack occur in the same cycle, the fault wins.
//  first_run clears after the first accepted sample. sign_prev updates on every accepted sample.
//  en low: state is held, counters are held, first_run is held. fault_ack still works.
//  worst_state and alarm are registered from the next-state values. They change in the same
//   cycle as state (latency 1 from the sample).
//  Outputs are fully registered. There are no combinational paths from inputs to outputs.
// STRUCTURE
//  constants.h (shared): `STATE_NORMAL/BORDERLINE/ATTENTION/EMERGENCY (2-bit, ordered 0..3),
//   cause bit indices `CAUSE_DELTA=0, `CAUSE_SIGN=1, `CAUSE_BCD=2.
//  Sub-module monitor_channel: one channel's classifier, persistence counter, fault latch and
//   first_run flag. The top uses a generate loop over NUM_CH plus a max-reduction and alarm OR.
//  Put a local function bcd_valid(W) in monitor_channel. Do not add a new shared package.
// TESTING
//  1 Reset: rst_n=0 two cycles with random inputs -> all state=0, fault=0, alarm=0.
//  2 Ch0 values 395,405,475,510 on successive strobes -> state 0,1,2,3, each 1 cycle after its strobe.
//  3 Ch1 at EMERGENCY, then values 485,485,485 with PERSIST=3 -> stays 3, 3, then 2 after the 3rd.
//    A 495 mid-sequence resets the count.
//  4 Ch2 first sample delta=099 -> no fault. Second sample delta=051 -> fault=1, cause=3'b001, state=3.
//    Ack plus a sign flip in the same cycle -> fault stays 1 with cause=3'b010.
//  5 Ch3 value 12'h3A0 -> bad_bcd cause set, alarm=1. fault_ack -> fault=0, then de-escalation after PERSIST samples.
//  6 All four channels strobed together with levels 0,1,2,0 -> worst_state=2 in the same cycle
//    as the states update. en=0 with strobes -> no change.

Source files
------------

// File: rtl/monitor_multi_pkg.sv
// monitor_multi_pkg: shared state encoding and fault cause bit positions for the multi-channel monitor
package monitor_multi_pkg;
  typedef enum logic [1:0] {
    ST_NORMAL     = 2'd0,
    ST_BORDERLINE = 2'd1,
    ST_ATTENTION  = 2'd2,
    ST_EMERGENCY  = 2'd3
  } level_t;
  localparam int CAUSE_DELTA = 0;
  localparam int CAUSE_SIGN  = 1;
  localparam int CAUSE_BCD   = 2;
endpackage

// File: rtl/monitor_channel.sv
// monitor_channel: one channel's level classifier, persistence counter, fault latch and first_run flag
//  clk, rst_n      clock, synchronous active-low reset
//  smp             sample accepted this cycle (enable already applied)
//  value_bcd/sign  sample magnitude and sign bit; delta_bcd |new - previous|
//  ack             clears the latched fault, its cause and the persistence count
//  state/state_d   registered level and its next value (feeds the top's reductions)
//  fault/fault_d   registered fault latch and its next value; cause {bad_bcd, sign_chg, delta}
module monitor_channel
  import monitor_multi_pkg::*;
#(
  parameter int                   DIGITS    = 3,
  parameter logic [4*DIGITS-1:0]  T_BORDER  = 'h400,
  parameter logic [4*DIGITS-1:0]  T_ATTN    = 'h470,
  parameter logic [4*DIGITS-1:0]  T_EMERG   = 'h500,
  parameter logic [4*DIGITS-1:0]  DELTA_MAX = 'h050,
  parameter logic [4*DIGITS-1:0]  HYST      = 'h010,
  parameter int                   PERSIST   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  smp,
  input  logic [4*DIGITS-1:0]   value_bcd,
  input  logic                  value_sign,
  input  logic [4*DIGITS-1:0]   delta_bcd,
  input  logic                  ack,
  output logic [1:0]            state,
  output logic [1:0]            state_d,
  output logic                  fault,
  output logic                  fault_d,
  output logic [2:0]            cause
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(PERSIST+1);
  function automatic logic bcd_valid(input logic [W-1:0] v);
    for (int d = 0; d < DIGITS; d++)
      if (v[4*d+:4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    int t;
    int br;
    r  = '0;
    br = 0;
    for (int d = 0; d < DIGITS; d++) begin
      t  = int'(a[4*d+:4]) - int'(b[4*d+:4]) - br;
      br = (t < 0) ? 1 : 0;
      t  = (t < 0) ? t + 10 : t;
      r[4*d+:4] = t[3:0];
    end
    return r;
  endfunction
  // De-escalation thresholds are taken in BCD so that e.g. 40.0-1.0 gives 39.0, not binary 0x3F0
  localparam logic [W-1:0] THR_B = bcd_sub(T_BORDER, HYST);
  localparam logic [W-1:0] THR_A = bcd_sub(T_ATTN,   HYST);
  localparam logic [W-1:0] THR_E = bcd_sub(T_EMERG,  HYST);
  logic [CW-1:0] cnt, cnt_b, cnt_i, cnt_d;
  logic          first_run, first_d, sign_prev, sign_d;
  logic [2:0]    cause_d, c_new;
  logic [W-1:0]  thr;
  level_t        lvl;
  always_comb begin
    lvl = (value_bcd < T_BORDER) ? ST_NORMAL :
          (value_bcd < T_ATTN)   ? ST_BORDERLINE :
          (value_bcd < T_EMERG)  ? ST_ATTENTION : ST_EMERGENCY;
    thr = (state == ST_BORDERLINE) ? THR_B : (state == ST_ATTENTION) ? THR_A : THR_E;
    c_new = '0;
    c_new[CAUSE_BCD]   = !bcd_valid(value_bcd) || !bcd_valid(delta_bcd);
    c_new[CAUSE_SIGN]  = !first_run && (value_sign != sign_prev);
    c_new[CAUSE_DELTA] = !first_run && (delta_bcd > DELTA_MAX);
    cnt_b   = ack ? '0 : cnt;
    cnt_i   = cnt_b + 1'b1;
    state_d = state;
    fault_d = fault && !ack;
    cause_d = ack ? 3'b000 : cause;
    cnt_d   = cnt_b;
    first_d = first_run;
    sign_d  = sign_prev;
    if (smp) begin
      first_d = 1'b0;
      sign_d  = value_sign;
      if (|c_new) begin
        // A new fault outranks an ack arriving in the same cycle
        fault_d = 1'b1;
        cause_d = cause_d | c_new;
        state_d = ST_EMERGENCY;
        cnt_d   = '0;
      end else if (!fault) begin
        if (lvl > state) begin
          state_d = lvl;
          cnt_d   = '0;
        end else if (state != ST_NORMAL && value_bcd < thr) begin
          state_d = (cnt_i == CW'(PERSIST)) ? lvl : state;
          cnt_d   = (cnt_i == CW'(PERSIST)) ? '0 : cnt_i;
        end else begin
          cnt_d = '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_NORMAL;
      cnt       <= '0;
      fault     <= 1'b0;
      cause     <= 3'b000;
      first_run <= 1'b1;
      sign_prev <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      fault     <= fault_d;
      cause     <= cause_d;
      first_run <= first_d;
      sign_prev <= sign_d;
    end
  end
endmodule

// File: rtl/monitor_multi.sv
// monitor_multi: N-channel BCD temperature classifier with hysteresis, persistence and latched faults
//  clk, rst_n    clock, synchronous active-low reset
//  en            global sample enable; smp_valid per-channel strobes
//  value_bcd     packed magnitudes, ch i at [i*W +: W]; value_sign per-channel sign
//  delta_bcd     packed |new - previous| magnitudes; fault_ack per-channel fault clear
//  state         packed 2-bit levels; worst_state max level; fault/fault_cause latched faults
//  alarm         any fault or worst level EMERGENCY; all outputs registered
module monitor_multi
  import monitor_multi_pkg::*;
#(
  parameter int                   NUM_CH    = 4,
  parameter int                   DIGITS    = 3,
  parameter logic [4*DIGITS-1:0]  T_BORDER  = 'h400,
  parameter logic [4*DIGITS-1:0]  T_ATTN    = 'h470,
  parameter logic [4*DIGITS-1:0]  T_EMERG   = 'h500,
  parameter logic [4*DIGITS-1:0]  DELTA_MAX = 'h050,
  parameter logic [4*DIGITS-1:0]  HYST      = 'h010,
  parameter int                   PERSIST   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_CH-1:0]           smp_valid,
  input  logic [NUM_CH*4*DIGITS-1:0]  value_bcd,
  input  logic [NUM_CH-1:0]           value_sign,
  input  logic [NUM_CH*4*DIGITS-1:0]  delta_bcd,
  input  logic [NUM_CH-1:0]           fault_ack,
  output logic [2*NUM_CH-1:0]         state,
  output logic [1:0]                  worst_state,
  output logic [NUM_CH-1:0]           fault,
  output logic [3*NUM_CH-1:0]         fault_cause,
  output logic                        alarm
);
  localparam int W = 4*DIGITS;
  logic [1:0]        st_d [NUM_CH];
  logic [NUM_CH-1:0] fault_d;
  logic [1:0]        worst_d;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    monitor_channel #(
      .DIGITS(DIGITS), .T_BORDER(T_BORDER), .T_ATTN(T_ATTN), .T_EMERG(T_EMERG),
      .DELTA_MAX(DELTA_MAX), .HYST(HYST), .PERSIST(PERSIST)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .smp        (en && smp_valid[g]),
      .value_bcd  (value_bcd[g*W+:W]),
      .value_sign (value_sign[g]),
      .delta_bcd  (delta_bcd[g*W+:W]),
      .ack        (fault_ack[g]),
      .state      (state[2*g+:2]),
      .state_d    (st_d[g]),
      .fault      (fault[g]),
      .fault_d    (fault_d[g]),
      .cause      (fault_cause[3*g+:3])
    );
  end
  // Reduce over next-state values so worst_state/alarm update in the same cycle as state
  always_comb begin
    worst_d = ST_NORMAL;
    for (int i = 0; i < NUM_CH; i++)
      worst_d = (st_d[i] > worst_d) ? st_d[i] : worst_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      worst_state <= ST_NORMAL;
      alarm       <= 1'b0;
    end else begin
      worst_state <= worst_d;
      alarm       <= (|fault_d) || (worst_d == ST_EMERGENCY);
    end
  end
endmodule
